// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Redirect, memory request/response and decode-side signals of the fetch sequencer.
interface fetch_if;
  import fetch_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
    output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
    input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries toward decode; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  // Storage is reset too so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC registers, credit-limited in-order issue, stale-response discard
// on redirect, and the decode FIFO.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  localparam int unsigned     CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);

  logic            start;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard_cnt;
  logic [CW-1:0]   count;
  logic [CW:0]     used;
  logic            req_valid, accept, resp_ok, keep, pop;
  fetch_entry_t    din, head;

  always_comb begin
    used      = {1'b0, count} + {1'b0, outstanding};
    req_valid = start && !bus.redirect_valid && (used < DEPTH_W);
    accept    = req_valid && bus.mem_req_ready;
    resp_ok   = bus.mem_resp_valid && (outstanding != '0);
    keep      = resp_ok && (discard_cnt == '0) && !bus.redirect_valid;
    pop       = (count != '0) && bus.inst_ready;
    din       = '{pc: resp_pc, instr: bus.mem_resp_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start       <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      start       <= 1'b1;
      outstanding <= outstanding + CW'(accept) - CW'(resp_ok);
      if (bus.redirect_valid) begin
        // Recomputed from outstanding every time, so back-to-back redirects never double-count.
        fetch_pc    <= align_pc(bus.redirect_pc);
        resp_pc     <= align_pc(bus.redirect_pc);
        discard_cnt <= outstanding - CW'(resp_ok);
      end else begin
        if (accept) fetch_pc <= fetch_pc + PC_STEP;
        if (keep)   resp_pc  <= resp_pc + PC_STEP;
        if (resp_ok && (discard_cnt != '0)) discard_cnt <= discard_cnt - 1'b1;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc;
  assign bus.inst_valid    = (count != '0);
  assign bus.inst_data     = head.instr;
  assign bus.inst_pc       = head.pc;

  a_resp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.mem_resp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a queue-based model of memory and decode stream.
module tb_fetch_ctrl;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch_ctrl #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        memq[$];
  logic [31:0] fifoq[$];
  logic [31:0] exp_fetch;
  bit          started;
  int          cyc, last_due;
  int          first_valid, watch_cyc, lat;
  int          p_ready, p_inst, p_redir, max_extra;
  logic [31:0] redir_base;
  bit          force_redir;
  logic [31:0] force_pc;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic model_reset();
    memq.delete();
    fifoq.delete();
    exp_fetch   = RPC;
    started     = 1'b0;
    cyc         = 0;
    last_due    = 0;
    first_valid = -1;
  endtask

  task automatic idle_inputs();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.inst_ready     = 1'b0;
  endtask

  task automatic run_cycle();
    req_t        r;
    bit          redir, rdy, irdy, resp, exp_rv, accept, popd;
    logic [31:0] rpc;
    int          due;
    @(posedge clk);
    cyc++;
    if (rst_n) started = 1'b1;
    #1;
    redir = force_redir || ($urandom_range(99) < p_redir);
    if (force_redir) rpc = force_pc;
    else if ($urandom_range(3) == 0) rpc = $urandom();
    else rpc = redir_base + ($urandom_range(63) << 2) + $urandom_range(3);
    force_redir = 1'b0;
    rdy  = $urandom_range(99) < p_ready;
    irdy = $urandom_range(99) < p_inst;
    resp = (memq.size() != 0) && (memq[0].due <= cyc);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.mem_req_ready  = rdy;
    bus.mem_resp_valid = resp;
    bus.mem_resp_data  = resp ? memf(memq[0].addr) : $urandom();
    bus.inst_ready     = irdy;
    #1;
    exp_rv = started && !redir && (fifoq.size() + memq.size() < DEPTH);
    check("req_valid", bus.mem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", bus.mem_req_addr, exp_fetch);
    check("inst_valid", bus.inst_valid, fifoq.size() != 0);
    if (fifoq.size() != 0) begin
      check("inst_pc", bus.inst_pc, fifoq[0]);
      check("inst_data", bus.inst_data, memf(fifoq[0]));
    end
    if (first_valid < 0 && bus.inst_valid) first_valid = cyc;
    if (watch_cyc >= 0 && cyc > watch_cyc && bus.inst_valid && lat < 0) lat = cyc - watch_cyc;
    // effects of the coming edge
    accept = exp_rv && rdy;
    popd   = (fifoq.size() != 0) && irdy;
    if (resp) r = memq.pop_front();
    if (redir) begin
      fifoq.delete();
      foreach (memq[i]) memq[i].stale = 1'b1;
      exp_fetch = {rpc[31:2], 2'b00};
    end else begin
      if (popd) void'(fifoq.pop_front());
      if (resp && !r.stale) fifoq.push_back(r.addr);
      if (accept) begin
        due = cyc + 2 + int'($urandom_range(max_extra));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        memq.push_back('{addr: exp_fetch, due: due, stale: 1'b0});
        exp_fetch = exp_fetch + 32'd4;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic knobs(input int rdy, input int inst, input int redir, input int extra);
    p_ready = rdy; p_inst = inst; p_redir = redir; max_extra = extra;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, bus.mem_req_valid, 1'b0);
    check({tag, "_inst_valid"}, bus.inst_valid, 1'b0);
    check({tag, "_inst_data"}, bus.inst_data, 32'h0);
    check({tag, "_inst_pc"}, bus.inst_pc, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    force_redir = 1'b0;
    force_pc    = '0;
    watch_cyc   = -1;
    lat         = -1;
    redir_base  = 32'h0000_4000;
    knobs(100, 100, 0, 0);
    model_reset();
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset and stream with a 1-cycle memory
    run(20);
    check("first_valid_edge", first_valid, 4);

    // Backpressure: decode stalls, credits run out, then release
    knobs(100, 0, 0, 0);
    run(10);
    check("bp_req_valid", bus.mem_req_valid, 1'b0);
    check("bp_inst_valid", bus.inst_valid, 1'b1);
    knobs(100, 100, 0, 0);
    run(12);

    // Redirect with two responses in flight
    force_redir = 1'b1;
    force_pc    = 32'h0000_2003;
    watch_cyc   = cyc + 1;
    lat         = -1;
    run(10);
    check("redir_latency", lat, 4);
    watch_cyc = -1;

    // Back-to-back redirects colliding with responses and pops
    force_redir = 1'b1;
    force_pc    = 32'h0000_3000;
    run_cycle();
    force_redir = 1'b1;
    force_pc    = 32'h0000_5008;
    run(15);
    check("discard_idle", dut.discard_cnt, 32'h0);

    // Random stalls across the 32-bit wrap
    knobs(60, 70, 0, 2);
    force_redir = 1'b1;
    force_pc    = 32'hFFFF_FFE0;
    run(200);

    // Mixed random traffic with frequent redirects
    knobs(70, 70, 8, 2);
    run(1500);
    knobs(80, 60, 30, 1);
    run(300);

    // Mid-stream reset
    knobs(100, 100, 0, 0);
    run(12);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    idle_inputs();
    model_reset();
    @(posedge clk);
    #2;
    check_reset_outputs("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    run(20);
    check("restart_first_valid", first_valid, 4);
    knobs(75, 75, 5, 2);
    run(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch sequencer between the core's PC logic and the instruction memory port (today the flat instruction RAM, later the ICache). It holds the fetch PC, issues in-order word requests under a credit limit, tags responses with their PC, buffers them in a small FIFO toward decode, and handles branch/jump redirects by flushing the buffer and discarding stale in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 4: FIFO entries, which is also the maximum in-flight plus buffered instructions. Power of two, at least 2.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset: one clock; reset is asynchronous and active-low.
- `redirect_valid`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new PC. Bits [1:0] are ignored and treated as 0.
- `mem_req_valid`  out  1  request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_addr`  out  32  byte address, word aligned.
- `mem_resp_valid`  in  1  one response word, returned in request order.
- `mem_resp_data`  in  32  instruction word.
- `inst_valid`  out  1  FIFO head is valid.
- `inst_ready`  in  1  decode consumes the head.
- `inst_data`  out  32  instruction.
- `inst_pc`  out  32  PC of `inst_data`.

## Operation
- **State**
  - `fetch_pc`: next request address.
  - `resp_pc`: PC of the next kept response.
  - `outstanding`: accepted requests not yet responded, range 0..DEPTH.
  - `discard_cnt`: in-flight responses to drop, range 0..DEPTH.
  - FIFO of {pc, instr} with `count`.
- **Start-up:** `start` flag, cleared at reset and set on the first clock after `rst_n` deasserts.
- **Issue:** `mem_req_valid = start && !redirect_valid && (count + outstanding < DEPTH)`.
  - `mem_req_addr = fetch_pc`.
  - On accept: `fetch_pc += 4` and `outstanding++`.
- **Response:**
  - Each `mem_resp_valid` decrements `outstanding`.
  - If `discard_cnt > 0`, the response is dropped and `discard_cnt` decrements.
  - Otherwise push {`resp_pc`, `mem_resp_data`} and `resp_pc += 4`.
  - The credit rule guarantees the push never overflows.
- **Pop:** happens when `inst_valid && inst_ready`. Push and pop in the same cycle leave `count` unchanged.
- **Redirect,** on the cycle `redirect_valid` is sampled high:
  - `fetch_pc` and `resp_pc` load `{redirect_pc[31:2], 2'b00}`.
  - The FIFO is cleared; redirect dominates a same-cycle push or pop.
  - `discard_cnt <= outstanding - mem_resp_valid`; a response arriving that cycle is dropped.
  - No request is issued that cycle.
  - Back-to-back redirects each recompute `discard_cnt` from `outstanding`, so no discard is double-counted.
- **Protocol violation:** `mem_resp_valid` with `outstanding == 0` is ignored; an assertion flags it.
- **PC arithmetic:** 32-bit with wrap-around. 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- **Reset (async assert) values:**
  - `mem_req_valid`=0, `inst_valid`=0.
  - `inst_data`=0, `inst_pc`=0.
  - `fetch_pc`=`resp_pc`=RESET_PC.
  - `count`=`outstanding`=`discard_cnt`=0, `start`=0.
- **After deassertion:** `mem_req_valid` goes high on the 2nd rising edge.
- **Latency:** request accepted at edge T, 1-cycle memory responds during T+1, push at T+2, `inst_valid` high in cycle T+2. This is 2 cycles from request accept to output valid.
- **Throughput:** each instruction holds a credit for 3 cycles, so DEPTH=4 sustains 1 instr/cycle with a 1-cycle memory. DEPTH=2 gives 2/3 instr/cycle.
- **Redirect:** first request at the new PC is issued the cycle after the redirect. First new instruction is valid 3 cycles after the redirect, with a 1-cycle memory and no discards pending.
- **Outputs:**
  - `inst_*` are driven from FIFO registers, with no combinational path from `mem_resp_*`.
  - `mem_req_valid` depends combinationally on `redirect_valid`.
- **Mid-operation reset:** all state clears. The memory must be reset together with this block.

## Structure
- **Package `fetch_pkg`:**
  - `fetch_entry_t` struct {logic [31:0] pc; logic [31:0] instr;}.
  - `PC_STEP`=4, `XLEN`=32.
- **Sub-module `fetch_fifo`:**
  - Synchronous FIFO of `fetch_entry_t`, parameterized by DEPTH.
  - Ports: `push`, `pop`, `flush`, `count`, head output; pointers wrap modulo DEPTH.
- **`fetch_ctrl`:** holds the PC registers, the credit and discard counters, and the `start` flag.

## Test plan
- **Reset and stream:** RESET_PC=0x100, 1-cycle memory, `inst_ready`=1. Expect `inst_pc` 0x100, 0x104, 0x108… on consecutive cycles with correct data, and first `inst_valid` on the 4th edge after deassertion.
- **Backpressure:** hold `inst_ready`=0. FIFO fills to 4; `mem_req_valid` drops once `count + outstanding` = 4. Release: no instruction lost or duplicated.
- **Redirect with discards:** 2 requests outstanding, redirect to 0x2003. Both stale responses are dropped. Next output is `inst_pc`=0x2000, followed by 0x2004.
- **Redirect collisions:** redirect coinciding with a response, a pop, and a second redirect next cycle. Only the last target's instructions appear, and `discard_cnt` returns to 0.
- **Variable memory stall:** randomized `mem_req_ready`. PC sequence stays contiguous and 32'hFFFF_FFFC wraps to 0.
- **Mid-stream reset:** assert `rst_n` low mid-stream. All outputs reach reset values immediately, and fetch restarts at RESET_PC.
